// File: rtl/sr_drv_pkg.sv
// Shared definitions for the SR_FF command driver: FSM encoding,
// counter sizing helper and skip-counter width.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        GAP   = 2'd3
    } drv_state_t;

    localparam int SKIP_CNT_W = 8;

    // Bits needed for a down-counter that starts at n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sr_cmd_driver_if.sv
// Request handshake between control logic and the SR_FF command driver.
interface sr_cmd_driver_if;

    logic req_valid;
    logic req_level;
    logic req_ready;

    modport master (output req_valid, output req_level, input req_ready);
    modport slave  (input req_valid, input req_level, output req_ready);

endinterface

// File: rtl/sr_req_fifo.sv
// 1-bit wide synchronous request FIFO. Pointers carry one extra wrap bit so
// full and empty are told apart by the MSB compare.
module sr_req_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic wr_en,
    input  logic wr_data,
    input  logic rd_en,
    output logic rd_data,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        mem [DEPTH];

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer advance on accepted write / read; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_en && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/sr_cmd_driver.sv
// Command-side driver for one SR_FF: queues target levels, turns each into an
// en/s/r pulse of PULSE_W cycles, verifies q afterwards and enforces a gap.
// s and r are only ever driven as complementary values together with en.
module sr_cmd_driver
    import sr_drv_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PULSE_W   = 2,
    parameter int GAP_W     = 1,
    parameter int SKIP_SAME = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    sr_cmd_driver_if.slave        req,
    input  logic                  q_fb,
    input  logic                  err_clear,
    output logic                  en,
    output logic                  s,
    output logic                  r,
    output logic                  busy,
    output logic                  err_mismatch,
    output logic [SKIP_CNT_W-1:0] skip_cnt
);
    localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_W > 0) ? GAP_W - 1 : 0);

    // Saturating increment for the skip counter.
    function automatic logic [SKIP_CNT_W-1:0] sat_inc(input logic [SKIP_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    drv_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             shadow;
    logic             fifo_full;
    logic             fifo_empty;
    logic             head;
    logic             push;
    logic             pop;

    assign push          = req.req_valid && !fifo_full;
    assign req.req_ready = !fifo_full;
    assign pop           = (state == IDLE) && !fifo_empty;
    assign busy          = (state != IDLE) || !fifo_empty;

    sr_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (req.req_level),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Command FSM: pop/skip, pulse timing, q verification, sticky error, skip count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            shadow       <= 1'b0;
            en           <= 1'b0;
            s            <= 1'b0;
            r            <= 1'b0;
            err_mismatch <= 1'b0;
            skip_cnt     <= '0;
        end else begin
            // Clear first so a mismatch detected this cycle overrides it.
            if (err_clear)
                err_mismatch <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        if ((SKIP_SAME != 0) && (head == shadow)) begin
                            skip_cnt <= sat_inc(skip_cnt);
                        end else begin
                            shadow <= head;
                            en     <= 1'b1;
                            s      <= head;
                            r      <= ~head;
                            cnt    <= PULSE_LOAD;
                            state  <= DRIVE;
                        end
                    end
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        en    <= 1'b0;
                        s     <= 1'b0;
                        r     <= 1'b0;
                        state <= CHECK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CHECK: begin
                    if (q_fb != shadow)
                        err_mismatch <= 1'b1;
                    if (GAP_W > 0) begin
                        cnt   <= GAP_LOAD;
                        state <= GAP;
                    end else begin
                        state <= IDLE;
                    end
                end
                GAP: begin
                    if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
